countdown_timer: RTL and testbench

- Loadable, prescaled down-counter with terminal-count detection. It is the counterpart to the team's up/up-down counters.
- Software or an FSM loads a count, starts it, and gets a one-cycle tc pulse plus a sticky done flag when the count expires.
- Optional auto-reload turns it into a periodic tick generator.
- Sits beside the counters as the timeout/delay source for control FSMs.

---
 rtl/countdown_timer_if.sv | 31 +++
 rtl/countdown_timer.sv | 121 ++++++++++++
 tb/tb_countdown_timer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Command/status bundle of the countdown timer.
// master drives commands, slave (the timer) returns status.
interface countdown_timer_if #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
);
    logic               act;
    logic               load;
    logic [WIDTH-1:0]   load_val;
    logic [PRESC_W-1:0] presc;
    logic               start;
    logic               stop;
    logic               auto_reload;
    logic               ack;
    logic [WIDTH-1:0]   out;
    logic               busy;
    logic               tc;
    logic               done;

    modport master (
        output act, load, load_val, presc,
        output start, stop, auto_reload, ack,
        input  out, busy, tc, done
    );

    modport slave (
        input  act, load, load_val, presc,
        input  start, stop, auto_reload, ack,
        output out, busy, tc, done
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable prescaled down-counter with a one-cycle terminal-count
// pulse, sticky done flag and optional periodic auto-reload.
module countdown_timer #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input logic              clk,
    input logic              reset,
    countdown_timer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0]   reload, reload_n;
    logic [PRESC_W-1:0] pcnt, pcnt_n;
    logic               tc, tc_n;
    logic               done, done_n;
    logic               tick;
    logic               cnt_zero;
    logic               reload_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            reload <= '0;
            pcnt   <= '0;
            tc     <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            reload <= reload_n;
            pcnt   <= pcnt_n;
            tc     <= tc_n;
            done   <= done_n;
        end
    end

    // >= so that lowering presc mid-count still ticks promptly
    assign tick        = bus.act && (pcnt >= bus.presc);
    assign cnt_zero    = (cnt == '0);
    assign reload_zero = (reload == '0);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        reload_n = reload;
        pcnt_n   = pcnt;
        tc_n     = 1'b0;
        done_n   = done & ~bus.ack;
        unique case (state)
            IDLE: begin
                if (!bus.stop) begin
                    if (bus.load) begin
                        reload_n = bus.load_val;
                        cnt_n    = bus.load_val;
                    end else if (bus.start && !cnt_zero) begin
                        state_n = RUN;
                        pcnt_n  = '0;
                    end
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_n = IDLE;
                    pcnt_n  = '0;
                end else begin
                    if (bus.load) begin
                        reload_n = bus.load_val;
                    end
                    if (tick) begin
                        pcnt_n = '0;
                        if (cnt > WIDTH'(1)) begin
                            cnt_n = cnt - WIDTH'(1);
                        end else begin
                            tc_n   = 1'b1;
                            done_n = 1'b1;
                            if (bus.auto_reload && !reload_zero) begin
                                cnt_n = reload;
                            end else begin
                                cnt_n   = '0;
                                state_n = DONE;
                            end
                        end
                    end else if (bus.act) begin
                        pcnt_n = pcnt + PRESC_W'(1);
                    end
                end
            end
            DONE: begin
                if (bus.stop) begin
                    state_n = IDLE;
                end else if (bus.load) begin
                    reload_n = bus.load_val;
                    cnt_n    = bus.load_val;
                    state_n  = IDLE;
                end else if (bus.start && !reload_zero) begin
                    cnt_n   = reload;
                    pcnt_n  = '0;
                    state_n = RUN;
                end else if (bus.ack) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.out  = cnt;
    assign bus.busy = (state == RUN);
    assign bus.tc   = tc;
    assign bus.done = done;
endmodule

// File: tb/tb_countdown_timer.sv
// Directed and randomized checks of countdown_timer against a
// behavioural reference model evaluated every cycle.
module tb_countdown_timer;
    localparam int WIDTH   = 8;
    localparam int PRESC_W = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DONE  = 2;

    typedef struct {
        int mode;
        int cnt;
        int reload;
        int pcnt;
        int tc;
        int done;
    } mstate_t;

    logic clk;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    countdown_timer_if #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) bus ();

    countdown_timer #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mstate_t ms = '{default: 0};

    function automatic mstate_t next_model(mstate_t s);
        mstate_t n = s;
        int lv = int'(bus.load_val);
        n.tc   = 0;
        n.done = (s.done != 0 && !bus.ack) ? 1 : 0;
        if (s.mode == M_RUN) begin
            if (bus.stop) begin
                n.mode = M_IDLE;
                n.pcnt = 0;
            end else begin
                if (bus.load) n.reload = lv;
                if (bus.act && s.pcnt < int'(bus.presc)) begin
                    n.pcnt = s.pcnt + 1;
                end else if (bus.act) begin
                    n.pcnt = 0;
                    if (s.cnt > 1) begin
                        n.cnt = s.cnt - 1;
                    end else begin
                        n.tc   = 1;
                        n.done = 1;
                        if (bus.auto_reload && s.reload != 0) begin
                            n.cnt = s.reload;
                        end else begin
                            n.cnt  = 0;
                            n.mode = M_DONE;
                        end
                    end
                end
            end
        end else if (bus.stop) begin
            n.mode = M_IDLE;
        end else if (bus.load) begin
            n.reload = lv;
            n.cnt    = lv;
            n.mode   = M_IDLE;
        end else if (bus.start && s.mode == M_IDLE && s.cnt != 0) begin
            n.mode = M_RUN;
            n.pcnt = 0;
        end else if (bus.start && s.mode == M_DONE && s.reload != 0) begin
            n.mode = M_RUN;
            n.cnt  = s.reload;
            n.pcnt = 0;
        end else if (s.mode == M_DONE && bus.ack) begin
            n.mode = M_IDLE;
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) ms <= '{default: 0};
        else       ms <= next_model(ms);
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_out",  32'(bus.out),  32'(ms.cnt));
        chk("model_busy", 32'(bus.busy), (ms.mode == M_RUN) ? 32'd1 : 32'd0);
        chk("model_tc",   32'(bus.tc),   32'(ms.tc));
        chk("model_done", 32'(bus.done), 32'(ms.done));
    end

    task automatic lit(string tag, int o, int b, int t, int d);
        chk({tag, ".out"},  32'(bus.out),  32'(o));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
        chk({tag, ".tc"},   32'(bus.tc),   32'(t));
        chk({tag, ".done"}, 32'(bus.done), 32'(d));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet();
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.ack   = 1'b0;
    endtask

    task automatic do_load(int v);
        bus.load     = 1'b1;
        bus.load_val = WIDTH'(v);
        step();
        bus.load     = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        quiet();
        bus.act         = 1'b1;
        bus.presc       = '0;
        bus.auto_reload = 1'b0;
        bus.load_val    = '0;
        #1;
        lit("reset", 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // one-shot, presc 0
        do_load(3);
        lit("os_load", 3, 0, 0, 0);
        do_start();
        lit("os_entry", 3, 1, 0, 0);
        step(); lit("os_n1", 2, 1, 0, 0);
        step(); lit("os_n2", 1, 1, 0, 0);
        step(); lit("os_n3", 0, 0, 1, 1);
        step(); lit("os_hold", 0, 0, 0, 1);
        bus.ack = 1'b1;
        step(); lit("os_ack", 0, 0, 0, 0);
        bus.ack = 1'b0;

        // prescale 2: decrement every third enabled cycle
        bus.presc = 4'd2;
        do_load(2);
        do_start();
        for (int i = 1; i <= 5; i++) begin
            step();
            lit($sformatf("pre_c%0d", i), (i < 3) ? 2 : 1, 1, 0, 0);
        end
        step(); lit("pre_tc", 0, 0, 1, 1);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;

        // presc lowered 3 -> 1 while pcnt = 2
        bus.presc = 4'd3;
        do_load(5);
        do_start();
        step(); step();
        lit("pdrop_pre", 5, 1, 0, 0);
        bus.presc = 4'd1;
        step(); lit("pdrop_tick", 4, 1, 0, 0);
        bus.stop = 1'b1;
        step(); lit("pdrop_stop", 4, 0, 0, 0);
        bus.stop = 1'b0;

        // auto-reload periodic mode
        bus.presc       = '0;
        bus.auto_reload = 1'b1;
        do_load(2);
        do_start();
        lit("ar_entry", 2, 1, 0, 0);
        step(); lit("ar_1", 1, 1, 0, 0);
        step(); lit("ar_tc1", 2, 1, 1, 1);
        step(); lit("ar_2", 1, 1, 0, 1);
        bus.ack = 1'b1;
        step(); lit("ar_ack_tc", 2, 1, 1, 1);
        step(); lit("ar_ack", 1, 1, 0, 0);
        bus.ack  = 1'b0;
        bus.stop = 1'b1;
        step();
        bus.stop        = 1'b0;
        bus.auto_reload = 1'b0;

        // pause freezes count and prescaler; stop holds count
        bus.presc = 4'd1;
        do_load(8);
        do_start();
        step(); lit("pz_pcnt1", 8, 1, 0, 0);
        bus.act = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); lit("pz_frozen", 8, 1, 0, 0);
        end
        bus.act = 1'b1;
        step(); lit("pz_resume", 7, 1, 0, 0);
        for (int i = 0; i < 6; i++) step();
        lit("pz_at4", 4, 1, 0, 0);
        bus.stop = 1'b1;
        step(); lit("pz_stop", 4, 0, 0, 0);
        bus.stop = 1'b0;
        do_start();
        lit("pz_restart", 4, 1, 0, 0);
        step(); step();
        lit("pz_cont", 3, 1, 0, 0);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;

        // corner commands
        bus.presc = '0;
        do_load(0);
        do_start();
        lit("zero_start", 0, 0, 0, 0);
        do_load(2);
        do_start();
        bus.load     = 1'b1;
        bus.load_val = 8'd9;
        step(); lit("run_load", 1, 1, 0, 0);
        bus.load = 1'b0;
        step(); lit("run_expire", 0, 0, 1, 1);
        do_start();
        lit("done_start", 9, 1, 0, 1);
        bus.stop     = 1'b1;
        bus.load     = 1'b1;
        bus.load_val = 8'd3;
        bus.start    = 1'b1;
        step(); lit("stop_wins", 9, 0, 0, 1);
        quiet();

        // asynchronous reset between edges
        do_load(5);
        do_start();
        step(); step();
        lit("rst_pre", 3, 1, 0, 1);
        #2 reset = 1'b1;
        #1 lit("rst_async", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        step(); lit("rst_idle", 0, 0, 0, 0);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            bus.act   = ($urandom_range(0, 4) != 0);
            bus.load  = ($urandom_range(0, 9) == 0);
            bus.start = ($urandom_range(0, 5) == 0);
            bus.stop  = ($urandom_range(0, 19) == 0);
            bus.ack   = ($urandom_range(0, 7) == 0);
            bus.presc = PRESC_W'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                bus.load_val = WIDTH'($urandom);
            else
                bus.load_val = WIDTH'($urandom_range(0, 6));
            if ($urandom_range(0, 49) == 0)
                bus.auto_reload = ~bus.auto_reload;
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end else begin
                step();
            end
        end
        quiet();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
